// File: rtl/adder_subtractor_multiprecision_pkg.sv
// Shared types and sizing helpers for the chained multiprecision adder/subtractor.
package adder_subtractor_multiprecision_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        STATE_LOAD = 2'b00,
        STATE_CALC = 2'b01,
        STATE_DONE = 2'b10
    } state_t;

    function automatic int step_count(input int word_width, input int step_width);
        return (word_width + step_width - 1) / step_width;
    endfunction

    function automatic int pad_width(input int word_width, input int step_width);
        return step_count(word_width, step_width) * step_width - word_width;
    endfunction

endpackage

// File: rtl/step_word_shift_register.sv
// Parallel-load register of DEPTH step words; each shift drops the lowest step word
// and inserts shift_in at the top, so operands stream out LSW first.
module step_word_shift_register #(
    parameter int STEP_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          clear_n,
    input  logic                          load,
    input  logic                          shift,
    input  logic [DEPTH*STEP_WIDTH-1:0]   load_data,
    input  logic [STEP_WIDTH-1:0]         shift_in,
    output logic [DEPTH*STEP_WIDTH-1:0]   data,
    output logic [STEP_WIDTH-1:0]         step_word
);
    localparam int TOTAL = DEPTH * STEP_WIDTH;

    logic [TOTAL-1:0] shifted;

    assign shifted   = (data >> STEP_WIDTH) | (TOTAL'(shift_in) << (TOTAL - STEP_WIDTH));
    assign step_word = data[STEP_WIDTH-1:0];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= shifted;
        end
    end

endmodule

// File: rtl/adder_subtractor_multiprecision_chained.sv
// Multiprecision add/sub through one STEP_WORD_WIDTH adder, LSW first, with chainable carry.
// Define ADDER_SUBTRACTOR_MULTIPRECISION_OUTPUT_BUFFER_EN for a result holding register.
module adder_subtractor_multiprecision_chained
    import adder_subtractor_multiprecision_pkg::*;
#(
    parameter int WORD_WIDTH      = 128,
    parameter int STEP_WORD_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [1:0]             op,
    input  logic                   carry_in,
    input  logic [WORD_WIDTH-1:0]  A,
    input  logic [WORD_WIDTH-1:0]  B,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  sum,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   zero,
    output logic                   negative
);
    localparam int S   = STEP_WORD_WIDTH;
    localparam int N   = step_count(WORD_WIDTH, STEP_WORD_WIDTH);
    localparam int P   = pad_width(WORD_WIDTH, STEP_WORD_WIDTH);
    localparam int EXT = N * S;
    localparam int Q   = S - P - 1;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t                state;
    state_t                calc_exit;
    op_t                   op_code;
    logic [CW-1:0]         step_cnt;
    logic                  carry_q;
    logic                  calc_carry;
    logic                  calc_overflow;
    logic                  calc_zero;
    logic                  init_carry;
    logic                  invert_b;
    logic                  accept;
    logic                  calc;
    logic                  last_step;
    logic                  top_carry;
    logic                  word_carry;
    logic                  word_overflow;
    logic [WORD_WIDTH-1:0] b_operand;
    logic [WORD_WIDTH-1:0] result_sum;
    logic [EXT-1:0]        a_load;
    logic [EXT-1:0]        b_load;
    logic [EXT-1:0]        sum_ext;
    logic [EXT-1:0]        a_data_unused;
    logic [EXT-1:0]        b_data_unused;
    logic [S-1:0]          a_step;
    logic [S-1:0]          b_step;
    logic [S-1:0]          sum_step_unused;
    logic [S:0]            step_full;

    assign op_code   = op_t'(op);
    assign invert_b  = op_code inside {OP_SUB, OP_SBC};
    assign b_operand = invert_b ? ~B : B;
    assign a_load    = EXT'($signed(A));
    assign b_load    = EXT'($signed(b_operand));

    always_comb begin
        init_carry = carry_in;
        case (op_code)
            OP_ADD:  init_carry = 1'b0;
            OP_SUB:  init_carry = 1'b1;
            default: init_carry = carry_in;
        endcase
    end

    assign accept    = (state == STATE_LOAD) && input_valid;
    assign calc      = (state == STATE_CALC);
    assign last_step = calc && (step_cnt == '0);

    step_word_shift_register #(.STEP_WIDTH(S), .DEPTH(N)) a_reg (
        .clock(clock), .clear_n(clear_n), .load(accept), .shift(calc),
        .load_data(a_load), .shift_in('0), .data(a_data_unused), .step_word(a_step)
    );

    step_word_shift_register #(.STEP_WIDTH(S), .DEPTH(N)) b_reg (
        .clock(clock), .clear_n(clear_n), .load(accept), .shift(calc),
        .load_data(b_load), .shift_in('0), .data(b_data_unused), .step_word(b_step)
    );

    step_word_shift_register #(.STEP_WIDTH(S), .DEPTH(N)) sum_reg (
        .clock(clock), .clear_n(clear_n), .load(1'b0), .shift(calc),
        .load_data('0), .shift_in(step_full[S-1:0]), .data(sum_ext), .step_word(sum_step_unused)
    );

    assign step_full = {1'b0, a_step} + {1'b0, b_step} + {{S{1'b0}}, carry_q};

    // Bit Q of the last step word is bit WORD_WIDTH-1; its carry-in and carry-out give the flags.
    assign top_carry     = a_step[Q] ^ b_step[Q] ^ step_full[Q];
    assign word_carry    = (a_step[Q] & b_step[Q]) | (top_carry & (a_step[Q] | b_step[Q]));
    assign word_overflow = word_carry ^ top_carry;
    assign result_sum    = WORD_WIDTH'((sum_ext >> S) | (EXT'(step_full[S-1:0]) << (EXT - S)));

`ifdef ADDER_SUBTRACTOR_MULTIPRECISION_OUTPUT_BUFFER_EN
    logic                  hold_valid;
    logic                  hold_carry;
    logic                  hold_overflow;
    logic                  hold_zero;
    logic                  hold_free;
    logic [WORD_WIDTH-1:0] hold_sum;

    assign hold_free = !hold_valid || output_ready;
    assign calc_exit = hold_free ? STATE_LOAD : STATE_DONE;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hold_valid    <= 1'b0;
            hold_carry    <= 1'b0;
            hold_overflow <= 1'b0;
            hold_zero     <= 1'b0;
            hold_sum      <= '0;
        end else if (last_step && hold_free) begin
            hold_valid    <= 1'b1;
            hold_carry    <= word_carry;
            hold_overflow <= word_overflow;
            hold_zero     <= (result_sum == '0);
            hold_sum      <= result_sum;
        end else if ((state == STATE_DONE) && output_ready) begin
            hold_valid    <= 1'b1;
            hold_carry    <= calc_carry;
            hold_overflow <= calc_overflow;
            hold_zero     <= calc_zero;
            hold_sum      <= sum_ext[WORD_WIDTH-1:0];
        end else if (output_ready) begin
            hold_valid    <= 1'b0;
        end
    end

    assign output_valid = hold_valid;
    assign sum          = hold_sum;
    assign carry_out    = hold_carry;
    assign overflow     = hold_overflow;
    assign zero         = hold_zero;
    assign negative     = hold_sum[WORD_WIDTH-1];
`else
    assign calc_exit    = STATE_DONE;
    assign output_valid = (state == STATE_DONE);
    assign sum          = sum_ext[WORD_WIDTH-1:0];
    assign carry_out    = calc_carry;
    assign overflow     = calc_overflow;
    assign zero         = calc_zero;
    assign negative     = sum_ext[WORD_WIDTH-1];
`endif

    assign input_ready = (state == STATE_LOAD);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state         <= STATE_LOAD;
            step_cnt      <= '0;
            carry_q       <= 1'b0;
            calc_carry    <= 1'b0;
            calc_overflow <= 1'b0;
            calc_zero     <= 1'b0;
        end else begin
            case (state)
                STATE_LOAD: begin
                    if (input_valid) begin
                        state    <= STATE_CALC;
                        step_cnt <= LAST_STEP;
                        carry_q  <= init_carry;
                    end
                end
                STATE_CALC: begin
                    step_cnt <= step_cnt - CW'(1);
                    carry_q  <= step_full[S];
                    if (step_cnt == '0) begin
                        calc_carry    <= word_carry;
                        calc_overflow <= word_overflow;
                        calc_zero     <= (result_sum == '0);
                        state         <= calc_exit;
                    end
                end
                STATE_DONE: begin
                    if (output_ready) begin
                        state <= STATE_LOAD;
                    end
                end
                default: state <= STATE_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_subtractor_multiprecision_chained.sv
// Scoreboard bench: 128/16 and 40/16 instances checked against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_adder_subtractor_multiprecision_chained;
    localparam int W0 = 128;
    localparam int S0 = 16;
    localparam int N0 = (W0 + S0 - 1) / S0;
    localparam int W1 = 40;
    localparam int S1 = 16;

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    logic clock = 1'b0;
    logic clear_n = 1'b1;

    logic          in_valid0, in_ready0, cin0, out_valid0, out_ready0, cout0, ovf0, zero0, neg0;
    logic [1:0]    op0;
    logic [W0-1:0] a0, b0, sum0;
    logic          in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, zero1, neg1;
    logic [1:0]    op1;
    logic [W1-1:0] a1, b1, sum1;

    res_t exp_q0[$];
    res_t exp_q1[$];
    res_t e0, e1;
    int   n_checks = 0;
    int   n_pass = 0;
    logic rand_rdy = 1'b0;

    adder_subtractor_multiprecision_chained #(.WORD_WIDTH(W0), .STEP_WORD_WIDTH(S0)) dut0 (
        .clock(clock), .clear_n(clear_n), .input_valid(in_valid0), .input_ready(in_ready0),
        .op(op0), .carry_in(cin0), .A(a0), .B(b0), .output_valid(out_valid0),
        .output_ready(out_ready0), .sum(sum0), .carry_out(cout0), .overflow(ovf0),
        .zero(zero0), .negative(neg0)
    );

    adder_subtractor_multiprecision_chained #(.WORD_WIDTH(W1), .STEP_WORD_WIDTH(S1)) dut1 (
        .clock(clock), .clear_n(clear_n), .input_valid(in_valid1), .input_ready(in_ready1),
        .op(op1), .carry_in(cin1), .A(a1), .B(b1), .output_valid(out_valid1),
        .output_ready(out_ready1), .sum(sum1), .carry_out(cout1), .overflow(ovf1),
        .zero(zero1), .negative(neg1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: w-bit two's complement arithmetic on wide integers.
    function automatic res_t model(input int w, input logic [1:0] op, input logic cin,
                                   input logic [127:0] a, input logic [127:0] b);
        res_t         r;
        logic [128:0] full;
        logic [127:0] mask, aa, bb;
        logic         c;
        mask   = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        aa     = a & mask;
        bb     = (op[0] ? ~b : b) & mask;
        c      = op[1] ? cin : op[0];
        full   = {1'b0, aa} + {1'b0, bb} + {128'd0, c};
        r.sum  = full[127:0] & mask;
        r.cout = full[w];
        r.neg  = r.sum[w-1];
        r.zero = (r.sum == 128'd0);
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] pick();
        case ($urandom_range(0, 5))
            0:       return {128{1'b1}};
            1:       return {1'b0, {127{1'b1}}};
            2:       return 128'd0;
            3:       return 128'h7F_FFFF_FFFF;
            default: return rnd128();
        endcase
    endfunction

    task automatic issue(input int sel, input logic [1:0] op, input logic cin,
                         input logic [127:0] a, input logic [127:0] b);
        int waited = 0;
        @(negedge clock);
        if (sel == 0) begin
            op0 = op; cin0 = cin; a0 = a; b0 = b; in_valid0 = 1'b1;
        end else begin
            op1 = op; cin1 = cin; a1 = a[W1-1:0]; b1 = b[W1-1:0]; in_valid1 = 1'b1;
        end
        while (((sel == 0) ? in_ready0 : in_ready1) !== 1'b1 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 300) begin
            note_fail("accept wait");
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
            return;
        end
        @(posedge clock);
        if (sel == 0) exp_q0.push_back(model(W0, op, cin, a, b));
        else          exp_q1.push_back(model(W1, op, cin, a, b));
        #1;
        // Operands are scrambled after the accepting edge; the DUT must have latched them.
        if (sel == 0) begin
            in_valid0 = 1'b0; a0 = rnd128(); b0 = rnd128(); op0 = 2'($urandom); cin0 = 1'($urandom);
        end else begin
            in_valid1 = 1'b0; a1 = W1'(rnd128()); b1 = W1'(rnd128()); op1 = 2'($urandom); cin1 = 1'($urandom);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 1000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 1000) note_fail("drain");
    endtask

    always @(negedge clock) begin
        if (clear_n && out_valid0 && out_ready0) begin
            if (exp_q0.size() == 0) note_fail("w128 unexpected result");
            else begin
                e0 = exp_q0.pop_front();
                chk("w128 sum", sum0, e0.sum);
                chk("w128 carry_out", 128'(cout0), 128'(e0.cout));
                chk("w128 overflow", 128'(ovf0), 128'(e0.ovf));
                chk("w128 zero", 128'(zero0), 128'(e0.zero));
                chk("w128 negative", 128'(neg0), 128'(e0.neg));
            end
        end
    end

    always @(negedge clock) begin
        if (clear_n && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) note_fail("w40 unexpected result");
            else begin
                e1 = exp_q1.pop_front();
                chk("w40 sum", 128'(sum1), e1.sum);
                chk("w40 carry_out", 128'(cout1), 128'(e1.cout));
                chk("w40 overflow", 128'(ovf1), 128'(e1.ovf));
                chk("w40 zero", 128'(zero1), 128'(e1.zero));
                chk("w40 negative", 128'(neg1), 128'(e1.neg));
            end
        end
    end

    always @(posedge clock) begin
        #2;
        if (rand_rdy) begin
            out_ready0 = ($urandom_range(0, 3) != 0);
            out_ready1 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic stuck;
        logic [127:0] ra, rb;
        in_valid0 = 1'b0; op0 = 2'b00; cin0 = 1'b0; a0 = '0; b0 = '0; out_ready0 = 1'b0;
        in_valid1 = 1'b0; op1 = 2'b00; cin1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
        #1 clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("reset input_ready", 128'(in_ready0), 128'd1);
        chk("reset output_valid", 128'(out_valid0), 128'd0);
        chk("reset sum", sum0, 128'd0);
        chk("reset carry_out", 128'(cout0), 128'd0);
        chk("reset overflow", 128'(ovf0), 128'd0);
        chk("reset zero", 128'(zero0), 128'd0);
        chk("reset negative", 128'(neg0), 128'd0);
        chk("reset w40 input_ready", 128'(in_ready1), 128'd1);
        @(negedge clock) clear_n = 1'b1;
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;

        issue(0, 2'b00, 1'b0, {128{1'b1}}, 128'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            n++;
            #1;
            if (out_valid0) break;
        end
        chk("w128 latency", 128'(n), 128'(N0));

        issue(0, 2'b01, 1'b0, 128'd0, 128'd1);
        issue(0, 2'b10, 1'b1, 128'd0, 128'd0);
        issue(0, 2'b11, 1'b0, 128'd5, 128'd3);
        issue(1, 2'b00, 1'b0, 128'h7F_FFFF_FFFF, 128'd1);
        wait_drain();

        @(posedge clock);
        #2 out_ready0 = 1'b0;
        issue(0, 2'b00, 1'b0, 128'd1, 128'd1);
`ifdef ADDER_SUBTRACTOR_MULTIPRECISION_OUTPUT_BUFFER_EN
        issue(0, 2'b00, 1'b0, 128'd2, 128'd2);
        repeat (N0 + 4) @(negedge clock);
        chk("buffered held input_ready", 128'(in_ready0), 128'd0);
        chk("buffered held output_valid", 128'(out_valid0), 128'd1);
        chk("buffered first result", sum0, 128'd2);
        @(posedge clock);
        #2 out_ready0 = 1'b1;
`else
        stuck = 1'b0;
        repeat (N0 + 16) begin
            @(negedge clock);
            if (in_ready0) stuck = 1'b1;
        end
        chk("unbuffered input_ready held low", 128'(stuck), 128'd0);
        chk("unbuffered output_valid waiting", 128'(out_valid0), 128'd1);
        @(posedge clock);
        #2 out_ready0 = 1'b1;
        issue(0, 2'b00, 1'b0, 128'd2, 128'd2);
`endif
        wait_drain();

        issue(0, 2'b00, 1'b0, rnd128(), rnd128());
        repeat (3) @(posedge clock);
        #2 clear_n = 1'b0;
        void'(exp_q0.pop_back());
        #1;
        chk("mid-calc reset output_valid", 128'(out_valid0), 128'd0);
        chk("mid-calc reset input_ready", 128'(in_ready0), 128'd1);
        @(negedge clock) clear_n = 1'b1;
        issue(0, 2'b00, 1'b0, 128'd3, 128'd4);
        wait_drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            ra = pick();
            rb = pick();
            issue((i % 4 == 3) ? 1 : 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        rand_rdy = 1'b0;
        @(posedge clock);
        #2;
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        wait_drain();
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_multiprecision_chained.md
# adder_subtractor_multiprecision_chained

Signed/unsigned multiprecision binary adder/subtractor that processes `WORD_WIDTH` operands as a sequence of `STEP_WORD_WIDTH` step words, least significant first, through a single narrow step adder. Compared with the single-mode multiprecision adder, it adds an external carry input for chaining wider arithmetic, four operation codes, zero/negative result flags and an optional output buffer. With the buffer, a new operation can start while the previous result still waits for its consumer. It sits between a ready/valid operand source and a ready/valid result sink in wide-integer datapaths, e.g. 128-bit counters or crypto bignum steps.

## Interface
- `WORD_WIDTH`, 128, operand/result width in bits (≥1)
- `STEP_WORD_WIDTH`, 16, bits per calculation step (1..`WORD_WIDTH`)
- `clock`  in  1  sole clock, rising edge
- `clear_n`  in  1  reset, asynchronous assert, active-low; deassertion synchronous to `clock` is the integrator's duty
- `input_valid`  in  1 / `input_ready`  out  1  operand handshake
- `op`  in  2  00 ADD (A+B), 01 SUB (A−B), 10 ADC (A+B+carry_in), 11 SBC (A+~B+carry_in)
- `carry_in`  in  1  used by ADC/SBC only; for SBC, 1 = no borrow
- `A`, `B`  in  `WORD_WIDTH`  operands
- `output_valid`  out  1 / `output_ready`  in  1  result handshake
- `sum`  out  `WORD_WIDTH`  result
- `carry_out`  out  1  unsigned carry; after SUB/SBC, 0 = borrow
- `overflow`  out  1  signed overflow
- `zero`  out  1  `sum` == 0
- `negative`  out  1  `sum[WORD_WIDTH-1]`

## Operation
- N = ceil(`WORD_WIDTH`/`STEP_WORD_WIDTH`); P = N·`STEP_WORD_WIDTH` − `WORD_WIDTH` pad bits, sign-extended into the top step word.
- Accept: `input_valid` && `input_ready` at a rising edge.
  - Latch `A` and `B`, inverting B for SUB/SBC.
  - Latch the initial carry: 0 for ADD, 1 for SUB, `carry_in` for ADC/SBC.
  - Inputs may change after the accepting edge.
- States:
  - LOAD: `input_ready`=1.
  - CALC: one step word per cycle for N cycles; step carry registered between steps.
  - DONE: `output_valid`=1.
- `carry_out` is the carry into bit `WORD_WIDTH` (not into the pad); `overflow` = carry into bit `WORD_WIDTH` XOR carry into bit `WORD_WIDTH`−1.
- `zero` and `negative` are computed from the registered `sum`, never from pad bits.
- Unbuffered flow: LOAD→CALC on accept; CALC→DONE on the last step; DONE→LOAD on output handshake. Outputs remain stable and valid throughout DONE.
- Reset (`clear_n`=0, any state including mid-CALC):
  - Immediately: `input_ready`=1, `output_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0, `zero`=0, `negative`=0, state LOAD.
  - Any in-flight operation is discarded.
- Illegal state encodings return to LOAD.

## Timing
- Accept at edge k → `output_valid` rises after edge k+N (latency N cycles); unbuffered throughput one result per N+2 cycles minimum.
- Output handshake at edge m → `input_ready` is high in the cycle after m (unbuffered).
- `input_ready` is never asserted combinationally from `input_valid`/`output_ready`; both ready and valid are registered-state decodes.
- N=1 is legal: CALC lasts exactly one cycle.

## Configuration
- `ADDER_SUBTRACTOR_MULTIPRECISION_OUTPUT_BUFFER_EN` defined: result and flags are copied into an output holding register on the last CALC edge.
  - If the holding register is empty (or read at that same edge), state returns to LOAD at that edge.
  - Otherwise the block waits in DONE (`input_ready`=0, calculation result held) until the holding register is read, then transfers at that edge and returns to LOAD.
  - `output_valid` reflects holding-register occupancy.
  - Sustained throughput: one result per N+1 cycles.
- Not defined: unbuffered flow as in Operation; no holding register is synthesised.

## Structure
- Package `adder_subtractor_multiprecision_pkg`:
  - `op_t` enum (OP_ADD, OP_SUB, OP_ADC, OP_SBC)
  - `state_t` enum (STATE_LOAD, STATE_CALC, STATE_DONE)
  - `step_count()`/`pad_width()` constant functions
- One sub-module: `step_word_shift_register`. It is a parallel-load, shift-by-one-step-word register of configurable depth, instantiated for A, B and sum.
- Step counter, carry register and FSM stay in the top module.

## Test plan
- 128/16, ADD A=2^128−1, B=1 → `sum`=0, `carry_out`=1, `overflow`=0, `zero`=1; `output_valid` exactly 8 cycles after accept.
- 128/16, SUB A=0, B=1 → `sum`=all ones, `carry_out`=0, `negative`=1, `overflow`=0.
- 40/16 (N=3, P=8), ADD A=0x7F_FFFF_FFFF, B=1 → `sum`=0x80_0000_0000, `overflow`=1, `carry_out`=0, `negative`=1.
- Chaining: ADC A=0, B=0, `carry_in`=1 → `sum`=1; SBC A=5, B=3, `carry_in`=0 → `sum`=1, `carry_out`=1.
- Two back-to-back accepts (A=1,B=1 then A=2,B=2), `output_ready`=0:
  - Buffered: second op is accepted and computed, then held in DONE; first read returns 2, next read returns 4.
  - Unbuffered: `input_ready` stays 0 until the first read.
- `clear_n` pulled low in the 4th CALC cycle → `output_valid`=0 and `input_ready`=1 without a clock edge; the next ADD 3+4 yields 7.
